seg_display_scheduler: RTL
==========================

Name: seg_display_scheduler

Overview:
- Time-shares the 8-digit seven-segment display between NUM_SRC independent value producers (debug counters, FSM state, sensor readouts).
- Grants sources round-robin, each for a programmable dwell time, and drives the selected 32-bit word to the display controller's val_in.
- Also reports which source is shown (for LED indication) and emits a one-cycle strobe on every source change.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- DWELL, 100_000_000, cycles a grant is held before re-arbitration (>=1).
- SRC_W, 2, width of source index; must equal clog2(NUM_SRC), minimum 1.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- req_in  input  NUM_SRC  bit i high = source i wants display time.
- vals_in  input  32*NUM_SRC  source i word at bits [32i+31:32i].
- pause_in  input  1  freezes dwell counter (hold current source).
- val_out  output  32  word to display controller.
- src_out  output  SRC_W  index of currently granted source.
- valid_out  output  1  high while a source is granted.
- switch_out  output  1  one-cycle pulse in first cycle of each new grant.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; outputs val_out=0, src_out=0, valid_out=0, switch_out=0.
  - rr_ptr=0, dwell_cnt=0.
- All outputs registered. No combinational path from inputs to outputs.
- Arbitration function:
  - Search starts at rr_ptr, increments modulo NUM_SRC, and picks the first index with req_in high.
  - rr_ptr is set to grant+1 (mod NUM_SRC) whenever a grant is issued.
- IDLE:
  - If req_in != 0 at an edge: grant the arbitration result, load src_out, set valid_out=1, switch_out=1, dwell_cnt=0, go to SHOW.
  - Otherwise hold, with val_out=0 and valid_out=0.
- SHOW (every edge):
  - val_out <= vals_in[slice src_out]. The displayed value tracks the live source with 1-cycle latency.
  - If req_in[src_out]=0: the grant ends immediately, regardless of pause_in or dwell_cnt.
    - If another source requests, grant it (switch_out=1, dwell_cnt=0).
    - Otherwise go to IDLE: valid_out=0, val_out=0, src_out holds its last value.
  - Else if pause_in=1: dwell_cnt holds and the grant holds.
  - Else if dwell_cnt==DWELL-1: re-arbitrate.
    - If the result is a different index: new grant, switch_out=1.
    - If the only requester is the current source: keep it, dwell_cnt=0, switch_out=0.
  - Else dwell_cnt++.
- Grant duration:
  - An unpaused, continuously requesting source is shown for exactly DWELL cycles (valid_out high, src_out constant).
  - The new source's value appears on val_out in the same cycle that src_out changes.
- switch_out is high only in the first cycle after a grant transition, including IDLE->SHOW. It is never high on a same-source renewal.
- DWELL=1: re-arbitration occurs every cycle.
- Counter width: clog2(DWELL), saturating logic not required.
- Reset asserted mid-grant: all state clears immediately and asynchronously, with no switch_out pulse on release.

Test Plan (DWELL=4, NUM_SRC=4):
- Reset: hold rst_n_in low with req_in=4'hF -> all outputs 0. Release -> next edge src_out=0, valid_out=1, switch_out=1.
- Rotation: req_in=4'b1011, vals_in word i = 32'hA000_000i -> src_out sequence 0,1,3,0,... each held 4 cycles. val_out=A000_0000, A000_0001, A000_0003 respectively. switch_out pulses once per change.
- Drop/idle:
  - Only req_in[2]=1 -> src 2 renewed every 4 cycles, switch_out never repeats.
  - Drop req_in[2] mid-dwell -> next edge valid_out=0, val_out=0, state IDLE.
- Pause: during src 1 at dwell_cnt=2, assert pause_in for 10 cycles -> src 1 shown 14 cycles total.
  - Drop req_in[1] while paused -> immediate switch to next requester.
- Live update: change vals_in slice of granted source from 32'h1234 to 32'h5678 -> val_out updates exactly 1 cycle later, with no switch_out.
- Async reset mid-SHOW: pull rst_n_in low between edges -> outputs 0 before the next clock edge. rr_ptr restarts at 0.

Source files
------------

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: round-robin time-sharing of the 7-seg display
// between NUM_SRC producers, each shown for DWELL cycles.
module seg_display_scheduler #(
  parameter int NUM_SRC = 4,
  parameter int DWELL   = 100_000_000,
  parameter int SRC_W   = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [NUM_SRC-1:0]     req_in,
  input  logic [32*NUM_SRC-1:0]  vals_in,
  input  logic                   pause_in,
  output logic [31:0]            val_out,
  output logic [SRC_W-1:0]       src_out,
  output logic                   valid_out,
  output logic                   switch_out
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t           r_state;
  logic [SRC_W-1:0] r_ptr;
  logic [CW-1:0]    r_cnt;

  logic             w_any;
  logic [SRC_W-1:0] w_gnt;
  logic [SRC_W-1:0] w_nxt;
  logic [31:0]      w_gval;
  logic [31:0]      w_cval;
  logic             w_end;
  logic             w_last;
  logic             w_grant;

  // First requester at or after ptr, wrapping modulo NUM_SRC.
  function automatic logic [SRC_W:0] arb(
    input logic [NUM_SRC-1:0] req,
    input logic [SRC_W-1:0]   ptr
  );
    logic [SRC_W:0] res;
    int             idx;
    res = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_SRC;
      if (req[idx]) res = {1'b1, SRC_W'(idx)};
    end
    return res;
  endfunction

  // Arbitration result and grant decision for this edge.
  always_comb begin
    {w_any, w_gnt} = arb(req_in, r_ptr);
    w_nxt = (int'(w_gnt) == NUM_SRC - 1) ? '0
          : SRC_W'(int'(w_gnt) + 1);
    w_gval = vals_in[32*int'(w_gnt) +: 32];
    w_cval = vals_in[32*int'(src_out) +: 32];
    w_end  = (r_state == SHOW) && !req_in[src_out];
    w_last = (r_cnt == LAST);
    w_grant = w_any && ((r_state == IDLE) || w_end ||
              (!pause_in && w_last && (w_gnt != src_out)));
  end

  // Grant FSM with registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_cnt      <= '0;
      val_out    <= '0;
      src_out    <= '0;
      valid_out  <= 1'b0;
      switch_out <= 1'b0;
    end else begin
      switch_out <= 1'b0;
      if (w_grant) begin
        r_state    <= SHOW;
        src_out    <= w_gnt;
        r_ptr      <= w_nxt;
        r_cnt      <= '0;
        val_out    <= w_gval;
        valid_out  <= 1'b1;
        switch_out <= 1'b1;
      end else if (r_state == IDLE || w_end) begin
        r_state   <= IDLE;
        val_out   <= '0;
        valid_out <= 1'b0;
      end else begin
        val_out <= w_cval;
        if (!pause_in) begin
          if (w_last) begin
            r_cnt <= '0;
            r_ptr <= w_nxt;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule
